// File: rtl/dlx_pkg.sv
// DLX decode shared definitions: opcodes, func codes,
// ALU operations, stage state and the decoded control bundle.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0a;
  localparam logic [5:0] OP_SUBUI = 6'h0b;
  localparam logic [5:0] OP_LHI   = 6'h0f;
  localparam logic [5:0] OP_TRAP  = 6'h11;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h04;
  localparam logic [5:0] F_SRL  = 6'h06;
  localparam logic [5:0] F_SRA  = 6'h07;
  localparam logic [5:0] F_NOP  = 6'h15;
  localparam logic [5:0] F_SEQ  = 6'h18;
  localparam logic [5:0] F_SNE  = 6'h19;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h28;
  localparam logic [5:0] F_SGT  = 6'h2b;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,  ALU_SUB = 5'd1,
    ALU_AND = 5'd2,  ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,  ALU_SLL = 5'd5,
    ALU_SRL = 5'd6,  ALU_SRA = 5'd7,
    ALU_SEQ = 5'd8,  ALU_SNE = 5'd9,
    ALU_SLT = 5'd10, ALU_SGT = 5'd11,
    ALU_LHI = 5'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_RUN, ST_FLUSH, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_BEQZ, BR_BNEZ, BR_J, BR_JR
  } br_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_wr;
    logic       ext_op;
    logic       alu_src;
    logic       mem_wr;
    logic       mem_rd;
    logic       mem_to_reg;
    logic       link;
    logic       illegal;
    logic       uses_rs2;
    logic       is_trap;
    logic       j26;
    alu_op_e    alu_op;
    br_e        br;
  } ctrl_t;

endpackage

// File: rtl/dlx_decode_comb.sv
// Pure combinational DLX field decode into a control
// bundle plus the extended immediate.
module dlx_decode_comb
  import dlx_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LINK_REG = 31
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [5:0] op;
  logic [5:0] fn;
  ctrl_t      c;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];

  always_comb begin
    c          = '0;
    c.rs1      = instr_i[25:21];
    c.rs2      = instr_i[20:16];
    c.rd       = instr_i[20:16];
    c.alu_op   = ALU_ADD;
    c.br       = BR_NONE;
    unique case (op)
      OP_RTYPE: begin
        c.rd       = instr_i[15:11];
        c.alu_src  = 1'b1;
        c.uses_rs2 = 1'b1;
        c.reg_wr   = 1'b1;
        unique case (fn)
          F_ADD, F_ADDU: c.alu_op = ALU_ADD;
          F_SUB:  c.alu_op = ALU_SUB;
          F_AND:  c.alu_op = ALU_AND;
          F_OR:   c.alu_op = ALU_OR;
          F_XOR:  c.alu_op = ALU_XOR;
          F_SLL:  c.alu_op = ALU_SLL;
          F_SRL:  c.alu_op = ALU_SRL;
          F_SRA:  c.alu_op = ALU_SRA;
          F_SLT:  c.alu_op = ALU_SLT;
          F_SGT:  c.alu_op = ALU_SGT;
          F_SEQ:  c.alu_op = ALU_SEQ;
          F_SNE:  c.alu_op = ALU_SNE;
          F_NOP:  c.reg_wr = 1'b0;
          default: begin
            c.reg_wr  = 1'b0;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        c.ext_op = 1'b1;
        c.reg_wr = 1'b1;
      end
      OP_ADDUI: c.reg_wr = 1'b1;
      OP_SUBI: begin
        c.ext_op = 1'b1;
        c.reg_wr = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_SUBUI: begin
        c.reg_wr = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_LHI: begin
        c.reg_wr = 1'b1;
        c.alu_op = ALU_LHI;
      end
      OP_LW, OP_LB, OP_LBU: begin
        c.ext_op     = 1'b1;
        c.reg_wr     = 1'b1;
        c.mem_rd     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW, OP_SB: begin
        c.ext_op   = 1'b1;
        c.mem_wr   = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OP_BEQZ: begin
        c.ext_op = 1'b1;
        c.br     = BR_BEQZ;
      end
      OP_BNEZ: begin
        c.ext_op = 1'b1;
        c.br     = BR_BNEZ;
      end
      OP_J: begin
        c.br  = BR_J;
        c.j26 = 1'b1;
      end
      OP_JAL: begin
        c.br     = BR_J;
        c.j26    = 1'b1;
        c.link   = 1'b1;
        c.rd     = 5'(LINK_REG);
        c.reg_wr = 1'b1;
      end
      OP_JR: c.br = BR_JR;
      OP_JALR: begin
        c.br     = BR_JR;
        c.link   = 1'b1;
        c.rd     = 5'(LINK_REG);
        c.reg_wr = 1'b1;
      end
      OP_TRAP: c.is_trap = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    // r0 is hardwired; never report a write to it
    if (c.rd == 5'd0) c.reg_wr = 1'b0;
  end

  assign ctrl_o = c;
  assign imm_o  = c.j26
    ? {{(XLEN-26){instr_i[25]}}, instr_i[25:0]}
    : c.ext_op
      ? {{(XLEN-16){instr_i[15]}}, instr_i[15:0]}
      : {{(XLEN-16){1'b0}}, instr_i[15:0]};

endmodule

// File: rtl/dlx_decode_stage.sv
// Registered DLX decode stage: branch resolution, load-use
// interlock, wrong-path flush and trap halt.
module dlx_decode_stage
  import dlx_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = 5,
  parameter int LINK_REG = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [31:0]        if_instr,
  input  logic [XLEN-1:0]    if_pc,
  output logic               id_ready,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [4:0]         ex_rd,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic               ex_reg_wr,
  output logic               ex_ext_op,
  output logic               ex_alu_src,
  output logic               ex_mem_wr,
  output logic               ex_mem_rd,
  output logic               ex_mem_to_reg,
  output logic               ex_link,
  output logic               ex_illegal,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0]    ex_imm,
  output logic [XLEN-1:0]    ex_pc,
  output logic               br_taken,
  output logic [XLEN-1:0]    br_target,
  output logic               halted
);

  ctrl_t           c;
  logic [XLEN-1:0] imm;
  state_e          state_q, state_d;
  logic            load_pend_q, load_pend_d;
  logic [4:0]      load_rd_q, load_rd_d;
  logic            hazard, adv, accept, issue;
  logic            taken;
  logic [XLEN-1:0] tgt;
  logic            ex_valid_q, br_taken_q;
  logic [XLEN-1:0] br_target_q, imm_q, pc_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [7:0]      flags_q;
  logic [ALUOP_W-1:0] alu_q;

  dlx_decode_comb #(
    .XLEN     (XLEN),
    .LINK_REG (LINK_REG)
  ) u_dec (
    .instr_i (if_instr),
    .ctrl_o  (c),
    .imm_o   (imm)
  );

  assign hazard = state_q == ST_RUN && load_pend_q && if_valid
    && (c.rs1 == load_rd_q
        || (c.uses_rs2 && c.rs2 == load_rd_q));
  assign adv    = !ex_valid_q || ex_ready;
  assign accept = if_valid && id_ready;
  assign issue  = accept && state_q == ST_RUN;

  always_comb begin
    taken = 1'b0;
    tgt   = if_pc + XLEN'(4) + imm;
    unique case (c.br)
      BR_BEQZ: taken = rs1_val == '0;
      BR_BNEZ: taken = rs1_val != '0;
      BR_J:    taken = 1'b1;
      BR_JR: begin
        taken = 1'b1;
        tgt   = rs1_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (issue && c.is_trap)   state_d = ST_HALT;
        else if (issue && taken)  state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (accept || !if_valid) state_d = ST_RUN;
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    id_ready = !rst && adv && state_q != ST_HALT && !hazard;
    halted   = state_q == ST_HALT;
  end

  always_comb begin
    load_pend_d = load_pend_q;
    load_rd_d   = load_rd_q;
    if (issue && c.mem_rd && c.rd != 5'd0) begin
      load_pend_d = 1'b1;
      load_rd_d   = c.rd;
    end else if (ex_ready) begin
      load_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      load_pend_q <= 1'b0;
      load_rd_q   <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      flags_q     <= '0;
      alu_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else begin
      br_taken_q  <= issue && taken;
      br_target_q <= (issue && taken) ? tgt : '0;
      load_pend_q <= load_pend_d;
      load_rd_q   <= load_rd_d;
      if (adv) begin
        ex_valid_q <= issue;
        if (issue) begin
          rd_q    <= c.rd;
          rs1_q   <= c.rs1;
          rs2_q   <= c.rs2;
          flags_q <= {c.reg_wr, c.ext_op, c.alu_src,
                      c.mem_wr, c.mem_rd, c.mem_to_reg,
                      c.link, c.illegal};
          alu_q   <= ALUOP_W'(c.alu_op);
          imm_q   <= imm;
          pc_q    <= if_pc;
        end
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rd      = rd_q;
  assign ex_rs1     = rs1_q;
  assign ex_rs2     = rs2_q;
  assign {ex_reg_wr, ex_ext_op, ex_alu_src,
          ex_mem_wr, ex_mem_rd, ex_mem_to_reg,
          ex_link, ex_illegal} = flags_q;
  assign ex_alu_op  = alu_q;
  assign ex_imm     = imm_q;
  assign ex_pc      = pc_q;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Directed table-driven bench for dlx_decode_stage
// plus hand sequences for stalls, flushes and halt.
module tb_dlx_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [31:0] rs1_val;
  logic        ex_ready;
  logic        ex_valid;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_reg_wr, ex_ext_op, ex_alu_src, ex_mem_wr;
  logic        ex_mem_rd, ex_mem_to_reg, ex_link, ex_illegal;
  logic [4:0]  ex_alu_op;
  logic [31:0] ex_imm, ex_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halted;

  always #5 clk = ~clk;

  dlx_decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .rs1_val       (rs1_val),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_reg_wr     (ex_reg_wr),
    .ex_ext_op     (ex_ext_op),
    .ex_alu_src    (ex_alu_src),
    .ex_mem_wr     (ex_mem_wr),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_link       (ex_link),
    .ex_illegal    (ex_illegal),
    .ex_alu_op     (ex_alu_op),
    .ex_imm        (ex_imm),
    .ex_pc         (ex_pc),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .halted        (halted)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [7:0]  fl;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        bt;
    logic [31:0] tgt;
  } out_t;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1v;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic out_t cur();
    return {ex_valid, ex_rd, ex_reg_wr, ex_ext_op, ex_alu_src,
            ex_mem_wr, ex_mem_rd, ex_mem_to_reg, ex_link,
            ex_illegal, ex_alu_op, ex_imm, ex_pc, br_taken,
            br_target};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s1, s2, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] s1,
    input logic [4:0] d, input logic [15:0] im);
    return {op, s1, d, im};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [5:0] op, input logic [25:0] im);
    return {op, im};
  endfunction

  task automatic add(
    input string nm, input logic [31:0] instr,
    input logic [31:0] pc, input logic [31:0] rs1v,
    input logic [4:0] rd, input logic [7:0] fl,
    input logic [4:0] alu, input logic [31:0] imm,
    input logic bt, input logic [31:0] tgt);
    vec_t t;
    t.nm = nm; t.instr = instr; t.pc = pc; t.rs1v = rs1v;
    t.exp = {1'b1, rd, fl, alu, imm, pc, bt, tgt};
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] instr,
                       input logic [31:0] pc,
                       input logic [31:0] rs1v);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    rs1_val  = rs1v;
  endtask

  localparam logic [4:0] A_ADD = 0, A_SUB = 1, A_SRA = 7;
  localparam logic [4:0] A_SEQ = 8, A_SGT = 11, A_LHI = 12;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0;
    if_pc = '0; rs1_val = '0; ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", cur(), '0);
    chk("reset_ready_halt", {id_ready, halted}, 2'b00);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", id_ready, 1'b1);

    // flags: reg_wr ext alu_src mem_wr mem_rd mem_to_reg link illegal
    add("addi", enc_i(6'h08,1,3,16'hFFFB), 32'h40, 0, 3,
        8'b1100_0000, A_ADD, 32'hFFFF_FFFB, 0, 0);
    add("add", enc_r(2,5,4,6'h20), 32'h44, 0, 4,
        8'b1010_0000, A_ADD, 32'h2020, 0, 0);
    add("sub", enc_r(8,9,7,6'h22), 32'h48, 0, 7,
        8'b1010_0000, A_SUB, 32'h3822, 0, 0);
    add("sra", enc_r(2,3,1,6'h07), 32'h4c, 0, 1,
        8'b1010_0000, A_SRA, 32'h0807, 0, 0);
    add("sgt", enc_r(6,7,5,6'h2b), 32'h50, 0, 5,
        8'b1010_0000, A_SGT, 32'h282b, 0, 0);
    add("seq", enc_r(1,2,10,6'h18), 32'h54, 0, 10,
        8'b1010_0000, A_SEQ, 32'h5018, 0, 0);
    add("nop", enc_r(0,0,0,6'h15), 32'h58, 0, 0,
        8'b0010_0000, A_ADD, 32'h15, 0, 0);
    add("add_r0", enc_r(1,2,0,6'h20), 32'h5c, 0, 0,
        8'b0010_0000, A_ADD, 32'h20, 0, 0);
    add("bad_func", enc_r(1,2,3,6'h3f), 32'h60, 0, 3,
        8'b0010_0001, A_ADD, 32'h183f, 0, 0);
    add("lw", enc_i(6'h23,1,2,16'h0008), 32'h64, 0, 2,
        8'b1100_1100, A_ADD, 32'h8, 0, 0);
    add("lbu", enc_i(6'h24,2,3,16'h0080), 32'h68, 0, 3,
        8'b1100_1100, A_ADD, 32'h80, 0, 0);
    add("sw", enc_i(6'h2b,1,6,16'hFFFC), 32'h6c, 0, 6,
        8'b0101_0000, A_ADD, 32'hFFFF_FFFC, 0, 0);
    add("lhi", enc_i(6'h0f,0,9,16'h8001), 32'h70, 0, 9,
        8'b1000_0000, A_LHI, 32'h8001, 0, 0);
    add("addui", enc_i(6'h09,1,4,16'hFFFF), 32'h74, 0, 4,
        8'b1000_0000, A_ADD, 32'hFFFF, 0, 0);
    add("subi_r0", enc_i(6'h0a,1,0,16'h0001), 32'h78, 0, 0,
        8'b0100_0000, A_SUB, 32'h1, 0, 0);
    add("beqz_t", enc_i(6'h04,1,0,16'h0010), 32'h100, 0, 0,
        8'b0100_0000, A_ADD, 32'h10, 1, 32'h114);
    add("bnez_nt", enc_i(6'h05,1,0,16'h0010), 32'h104, 0, 0,
        8'b0100_0000, A_ADD, 32'h10, 0, 0);
    add("bnez_t", enc_i(6'h05,1,0,16'hFFF0), 32'h300, 5, 0,
        8'b0100_0000, A_ADD, 32'hFFFF_FFF0, 1, 32'h2F4);
    add("jal", enc_j(6'h03,26'h40), 32'h200, 0, 31,
        8'b1000_0010, A_ADD, 32'h40, 1, 32'h244);
    add("j", enc_j(6'h02,26'h3FFFFF0), 32'h1000, 0, 31,
        8'b0000_0000, A_ADD, 32'hFFFF_FFF0, 1, 32'hFF4);
    add("jr", enc_i(6'h12,5,0,16'h0), 32'h400, 32'h1234_5678, 0,
        8'b0000_0000, A_ADD, 32'h0, 1, 32'h1234_5678);
    add("jalr", enc_i(6'h13,6,0,16'h0), 32'h404, 32'h800, 31,
        8'b1000_0010, A_ADD, 32'h0, 1, 32'h800);
    add("bad_op", enc_i(6'h3e,1,2,16'h1234), 32'h408, 0, 2,
        8'b0000_0001, A_ADD, 32'h1234, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1v);
      @(negedge clk);
      if_valid = 1'b0;
      chk(vecs[i].nm, cur(), vecs[i].exp);
    end

    // load-use: one bubble, add issues two cycles after lw
    @(negedge clk);
    drive(enc_i(6'h23,1,2,16'h0), 32'h600, 0);
    @(negedge clk);
    drive(enc_r(2,5,4,6'h20), 32'h604, 0);
    #1;
    chk("lu_load_out", {ex_valid, ex_rd, ex_mem_rd}, {1'b1, 5'd2, 1'b1});
    chk("lu_stall_ready", id_ready, 1'b0);
    @(negedge clk);
    chk("lu_bubble", {ex_valid, id_ready}, 2'b01);
    @(negedge clk);
    if_valid = 1'b0;
    chk("lu_add_issue", {ex_valid, ex_rd, ex_pc}, {1'b1, 5'd4, 32'h604});

    // taken branch flushes the next fetched instruction
    @(negedge clk);
    drive(enc_i(6'h04,1,0,16'h0010), 32'h100, 0);
    @(negedge clk);
    drive(enc_i(6'h08,0,7,16'h1), 32'h104, 0);
    #1;
    chk("br_pulse", {br_taken, br_target}, {1'b1, 32'h114});
    chk("flush_accepts", id_ready, 1'b1);
    @(negedge clk);
    chk("flush_discard", {br_taken, ex_valid}, 2'b00);
    drive(enc_i(6'h08,0,8,16'h2), 32'h114, 0);
    @(negedge clk);
    if_valid = 1'b0;
    chk("after_flush", {ex_valid, ex_rd, ex_pc}, {1'b1, 5'd8, 32'h114});

    // back-pressure holds outputs for three cycles
    @(negedge clk);
    drive(enc_r(1,2,4,6'h20), 32'h500, 0);
    @(negedge clk);
    ex_ready = 1'b0;
    drive(enc_r(1,2,5,6'h22), 32'h504, 0);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_hold%0d", k),
          {ex_valid, ex_rd, ex_pc, ex_alu_op, id_ready},
          {1'b1, 5'd4, 32'h500, A_ADD, 1'b0});
      @(negedge clk);
    end
    ex_ready = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    chk("stall_release", {ex_valid, ex_rd, ex_pc, ex_alu_op},
        {1'b1, 5'd5, 32'h504, A_SUB});

    // jal stalled by EX: redirect pulse stays one cycle
    @(negedge clk);
    drive(enc_j(6'h03,26'h10), 32'h700, 0);
    @(negedge clk);
    ex_ready = 1'b0;
    drive(enc_i(6'h08,0,9,16'h1), 32'h704, 0);
    #1;
    chk("jal_pulse", {br_taken, br_target}, {1'b1, 32'h714});
    @(negedge clk);
    chk("jal_stall", {br_taken, id_ready, ex_valid, ex_rd},
        {1'b0, 1'b0, 1'b1, 5'd31});
    ex_ready = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    chk("jal_discard", ex_valid, 1'b0);

    // trap halts until reset
    @(negedge clk);
    drive(enc_i(6'h11,0,0,16'h0), 32'h800, 0);
    @(negedge clk);
    drive(enc_i(6'h08,0,3,16'h1), 32'h804, 0);
    #1;
    chk("trap_issue", {ex_valid, halted, id_ready}, 3'b110);
    @(negedge clk);
    chk("halt_frozen", {ex_valid, halted, id_ready}, 3'b010);
    @(negedge clk);
    chk("halt_hold", {ex_valid, halted, id_ready}, 3'b010);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clear", cur(), '0);
    chk("rst_flags", {halted, id_ready}, 2'b00);
    rst = 1'b0;
    #1;
    chk("rst_ready", id_ready, 1'b1);
    @(negedge clk);
    if_valid = 1'b0;
    chk("rst_accept", {ex_valid, ex_rd, ex_pc}, {1'b1, 5'd3, 32'h804});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dlx_decode_stage.md
# dlx_decode_stage

Registered, parametrised DLX instruction-decode stage: decodes one fetched instruction per cycle into EX-stage control, resolves BEQZ/BNEZ/J/JAL/JR/JALR in decode, and interlocks load-use hazards. It sits between the fetch buffer (valid/ready) and the EX stage (valid/ready). It replaces the purely combinational control decoder with a pipelined, back-pressure-aware stage that also flushes the wrong path.

## Interface
- XLEN, 32: datapath/PC width; immediates sign- or zero-extend to XLEN.
- ALUOP_W, 5: ALU opcode width.
- LINK_REG, 31: destination register for JAL/JALR.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  stage accepts if_instr this cycle
- rs1_val  in  XLEN  register-file value of if_instr[25:21], same cycle
- ex_ready  in  1  EX accepts current outputs
- ex_valid  out  1  outputs below are valid
- ex_rd, ex_rs1, ex_rs2  out  5 each  register indices
- ex_reg_wr, ex_ext_op, ex_alu_src, ex_mem_wr, ex_mem_rd, ex_mem_to_reg, ex_link, ex_illegal  out  1 each  control flags
- ex_alu_op  out  ALUOP_W  ALU operation
- ex_imm, ex_pc  out  XLEN  extended immediate, instruction PC
- br_taken  out  1  redirect pulse to fetch
- br_target  out  XLEN  redirect PC
- halted  out  1  TRAP retired; stage frozen

## Operation
- Fields: opcode [31:26], rs1 [25:21], rs2 [20:16], R-type rd [15:11], func [5:0], imm16 [15:0], imm26 [25:0]; I-type rd = rs2 field.
- R-type (opcode 0x00): func add 0x20, addu 0x21, sub 0x22, and 0x24, or 0x25, xor 0x26, sll 0x04, srl 0x06, sra 0x07, slt 0x28, sgt 0x2b, seq 0x18, sne 0x19, nop 0x15 (no write); ex_alu_src=1 (register).
- I-type: addi 0x08, addui 0x09, subi 0x0a, subui 0x0b, lhi 0x0f, lw 0x23, lb 0x20, lbu 0x24, sw 0x2b, sb 0x28; ex_alu_src=0. ex_ext_op=1 (sign) for addi, subi, loads, stores, branches; 0 otherwise.
- Loads: ex_mem_rd=ex_mem_to_reg=1, alu ADD. Stores: ex_mem_wr=1, ex_reg_wr=0, alu ADD.
- ex_reg_wr forced 0 when destination index is 0.
- Branches: beqz 0x04 taken iff rs1_val==0; bnez 0x05 iff rs1_val!=0; target = pc+4+sext(imm16). j 0x02/jal 0x03 always, target = pc+4+sext(imm26). jr 0x12/jalr 0x13 target = rs1_val. jal/jalr: ex_link=1, ex_rd=LINK_REG, ex_reg_wr=1.
- trap 0x11: issued with ex_valid, then state HALT. Unknown opcode/func: ex_illegal=1, all write/mem flags 0.
- States: RUN (normal); FLUSH (one cycle after a taken branch issues; any accepted if_instr is discarded, not issued; then RUN); HALT (id_ready=0, ex_valid drops after EX accepts; exit only via rst).
- Load-use interlock: flag load_pend + load_rd set when a load with rd!=0 issues; cleared on the next cycle where ex_ready=1. If load_pend and incoming rs1 or (R-type/store) rs2 equals load_rd: id_ready=0, a bubble (ex_valid=0) is issued, load_pend cleared, instruction accepted next cycle.

## Timing
- Reset: all outputs 0, id_ready 0 during rst, state RUN, load_pend 0.
- Latency: accept at edge N -> ex_* valid from cycle N+1.
- Accept = if_valid && id_ready; id_ready = (!ex_valid || ex_ready) && state!=HALT && !hazard.
- ex_ready=0 with ex_valid=1: all ex_* held stable; nothing accepted.
- br_taken/br_target registered: asserted exactly one cycle, coincident with the branch's ex_valid cycle; that same cycle is FLUSH.
- Taken branch stalled by ex_ready: br_taken still one cycle only; FLUSH persists until one wrong-path instruction is discarded or fetch shows if_valid=0 for that cycle.
- rst mid-stall/flush/halt: returns to reset state next edge.

## Structure
- Shared package dlx_pkg: opcode and func constants, ALU op enum (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SEQ 8, SNE 9, SLT 10, SGT 11, LHI 12), state enum.
- Sub-module dlx_decode_comb: pure combinational field decode -> control bundle; the stage adds branch resolution, hazard, FSM, output register.

## Test plan
- addi r3,r1,#-5 at pc 0x40 -> next cycle ex_rd=3, ex_reg_wr=1, ex_alu_src=0, ex_ext_op=1, ex_imm=0xFFFFFFFB, ex_alu_op=ADD.
- lw r2,0(r1) then add r4,r2,r5 -> one bubble cycle, id_ready=0 one cycle, add issues second cycle after lw.
- beqz r1,#0x10 at pc 0x100 with rs1_val=0 -> br_taken one cycle, br_target=0x114; following if_instr discarded.
- bnez with rs1_val=0 -> br_taken=0, next instruction issues normally; jal at pc 0x200 -> ex_rd=31, ex_link=1.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, id_ready=0; add r0,r1,r2 -> ex_reg_wr=0.
- trap -> halted=1, id_ready stays 0; rst asserted -> all outputs 0, accepts on following cycle.
